// File: rtl/sync_fifo_flex_if.sv
// rtl/sync_fifo_flex_if.sv - producer/consumer bundle for sync_fifo_flex
interface sync_fifo_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - parametrised single-clock FIFO, registered-read or FWFT
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_flex_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_CNT = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT = (AW + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           w_ptr;
  logic [AW:0]           r_ptr;
  logic [AW:0]           count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [AW-1:0]         w_idx;
  logic [AW-1:0]         r_idx;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_ok;
  logic                  rd_ok;

  assign w_idx   = w_ptr[AW-1:0];
  assign r_idx   = r_ptr[AW-1:0];
  // The extra pointer bit separates a wrapped-full FIFO from an empty one.
  assign full_w  = (w_ptr[AW] != r_ptr[AW]) && (w_idx == r_idx);
  assign empty_w = (w_ptr == r_ptr);
  assign wr_ok   = bus.wr_en && !full_w;
  assign rd_ok   = bus.rd_en && !empty_w;

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[w_idx] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        w_ptr <= w_ptr + 1'b1;
      end
      if (rd_ok) begin
        r_ptr <= r_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A fresh error in the same cycle as clr_err keeps the flag set.
      overflow_q  <= (overflow_q && !bus.clr_err) || (bus.wr_en && full_w);
      underflow_q <= (underflow_q && !bus.clr_err) || (bus.rd_en && empty_w);
    end
  end

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  if (FWFT) begin : g_fwft
    // Head word is presented directly; data is forced to zero while empty.
    assign bus.data_out = empty_w ? '0 : mem[r_idx];
    assign bus.valid    = !empty_w;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) begin
          data_q <= mem[r_idx];
        end
      end
    end

    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
  end
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - self-checking bench for sync_fifo_flex in both read modes
module tb_sync_fifo_flex;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
  sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: contents as a queue, plus registered-read output and sticky errors.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_udf;

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    bit was_full;
    bit was_empty;
    bus0.wr_en = w; bus0.data_in = d; bus0.rd_en = r; bus0.clr_err = c;
    bus1.wr_en = w; bus1.data_in = d; bus1.rd_en = r; bus1.clr_err = c;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ovf   = (m_ovf && !c) || (w && was_full);
      m_udf   = (m_udf && !c) || (r && was_empty);
      m_valid = r && !was_empty;
      if (m_valid) m_dout = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    @(negedge clk);
  endtask

  function automatic logic [10:0] exp_status();
    int n = q.size();
    return {n == DEPTH, n == 0, n >= DEPTH - 2, n <= 2, m_ovf, m_udf, 5'(n)};
  endfunction

  function automatic logic [10:0] st0();
    return {bus0.full, bus0.empty, bus0.almost_full, bus0.almost_empty,
            bus0.overflow, bus0.underflow, bus0.count};
  endfunction

  function automatic logic [10:0] st1();
    return {bus1.full, bus1.empty, bus1.almost_full, bus1.almost_empty,
            bus1.overflow, bus1.underflow, bus1.count};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    rst = 1'b0;
    n_vec++; if (st0() !== exp_status()) begin n_err++; $display("FAIL reset_status0 got=%h exp=%h", st0(), exp_status()); end
    n_vec++; if (st1() !== exp_status()) begin n_err++; $display("FAIL reset_status1 got=%h exp=%h", st1(), exp_status()); end
    n_vec++; if (bus0.data_out !== 8'h00) begin n_err++; $display("FAIL reset_dout got=%h exp=00", bus0.data_out); end
    n_vec++; if (bus0.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid0 got=%b exp=0", bus0.valid); end
    n_vec++; if (bus1.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid1 got=%b exp=0", bus1.valid); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      n_vec++; if (st0() !== exp_status()) begin n_err++; $display("FAIL fill_status0 i=%0d got=%h exp=%h", i, st0(), exp_status()); end
      n_vec++; if (st1() !== exp_status()) begin n_err++; $display("FAIL fill_status1 i=%0d got=%h exp=%h", i, st1(), exp_status()); end
    end
    n_vec++; if (bus0.full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", bus0.full); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_vec++; if (bus0.data_out !== 8'(i)) begin n_err++; $display("FAIL drain_dout i=%0d got=%h exp=%h", i, bus0.data_out, 8'(i)); end
      n_vec++; if (bus0.valid !== 1'b1) begin n_err++; $display("FAIL drain_valid i=%0d got=%b exp=1", i, bus0.valid); end
      n_vec++; if (st0() !== exp_status()) begin n_err++; $display("FAIL drain_status0 i=%0d got=%h exp=%h", i, st0(), exp_status()); end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_vec++; if (bus0.valid !== 1'b0) begin n_err++; $display("FAIL drain_valid_drop got=%b exp=0", bus0.valid); end
    n_vec++; if (bus0.empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b exp=1", bus0.empty); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    n_vec++; if (st0() !== exp_status()) begin n_err++; $display("FAIL ovf_status0 got=%h exp=%h", st0(), exp_status()); end
    n_vec++; if (bus0.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", bus0.overflow); end
    n_vec++; if (bus1.data_out !== 8'h00) begin n_err++; $display("FAIL ovf_head got=%h exp=00", bus1.data_out); end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    n_vec++; if (bus0.data_out !== 8'h0F) begin n_err++; $display("FAIL ovf_last_word got=%h exp=0f", bus0.data_out); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_vec++; if (st0() !== exp_status()) begin n_err++; $display("FAIL udf_status0 got=%h exp=%h", st0(), exp_status()); end
    n_vec++; if (bus0.underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag got=%b exp=1", bus0.underflow); end
    n_vec++; if (bus0.data_out !== 8'h0F) begin n_err++; $display("FAIL udf_dout_hold got=%h exp=0f", bus0.data_out); end
    n_vec++; if (bus0.valid !== 1'b0) begin n_err++; $display("FAIL udf_valid got=%b exp=0", bus0.valid); end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    n_vec++; if ({bus0.overflow, bus0.underflow} !== 2'b01) begin n_err++; $display("FAIL clr_set_wins got=%b exp=01", {bus0.overflow, bus0.underflow}); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_vec++; if ({bus0.overflow, bus0.underflow} !== 2'b00) begin n_err++; $display("FAIL clr_err got=%b exp=00", {bus0.overflow, bus0.underflow}); end
    n_vec++; if (st1() !== exp_status()) begin n_err++; $display("FAIL clr_status1 got=%h exp=%h", st1(), exp_status()); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0);
      n_vec++; if (st0() !== exp_status()) begin n_err++; $display("FAIL simul_status0 i=%0d got=%h exp=%h", i, st0(), exp_status()); end
      n_vec++; if (bus0.count !== 5'd5) begin n_err++; $display("FAIL simul_count i=%0d got=%0d exp=5", i, bus0.count); end
      n_vec++; if (bus0.data_out !== m_dout) begin n_err++; $display("FAIL simul_dout0 i=%0d got=%h exp=%h", i, bus0.data_out, m_dout); end
      n_vec++; if (bus1.data_out !== q[0]) begin n_err++; $display("FAIL simul_head1 i=%0d got=%h exp=%h", i, bus1.data_out, q[0]); end
    end
    while (q.size() < DEPTH) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 1'b1, 1'b0);
    n_vec++; if (st0() !== exp_status()) begin n_err++; $display("FAIL full_both_status0 got=%h exp=%h", st0(), exp_status()); end
    n_vec++; if (bus0.count !== 5'd15) begin n_err++; $display("FAIL full_both_count got=%0d exp=15", bus0.count); end
    n_vec++; if (bus0.data_out !== m_dout) begin n_err++; $display("FAIL full_both_dout got=%h exp=%h", bus0.data_out, m_dout); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_fwft();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    n_vec++; if (bus1.valid !== 1'b1) begin n_err++; $display("FAIL fwft_valid got=%b exp=1", bus1.valid); end
    n_vec++; if (bus1.data_out !== 8'hA5) begin n_err++; $display("FAIL fwft_dout got=%h exp=a5", bus1.data_out); end
    n_vec++; if (bus0.valid !== 1'b0) begin n_err++; $display("FAIL fwft_reg_no_bypass got=%b exp=0", bus0.valid); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_vec++; if (bus1.valid !== 1'b0) begin n_err++; $display("FAIL fwft_pop_valid got=%b exp=0", bus1.valid); end
    n_vec++; if (st1() !== exp_status()) begin n_err++; $display("FAIL fwft_pop_status1 got=%h exp=%h", st1(), exp_status()); end
    n_vec++; if (bus0.data_out !== 8'hA5) begin n_err++; $display("FAIL fwft_reg_dout got=%h exp=a5", bus0.data_out); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    n_vec++; if (bus0.count !== 5'd9) begin n_err++; $display("FAIL mid_pre_count got=%0d exp=9", bus0.count); end
    rst = 1'b1;
    step(1'b1, 8'($urandom), 1'b0, 1'b0);
    rst = 1'b0;
    n_vec++; if (st0() !== exp_status()) begin n_err++; $display("FAIL mid_rst_status0 got=%h exp=%h", st0(), exp_status()); end
    n_vec++; if (bus0.empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty got=%b exp=1", bus0.empty); end
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    n_vec++; if (bus1.data_out !== 8'h3C) begin n_err++; $display("FAIL mid_head1 got=%h exp=3c", bus1.data_out); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_vec++; if (bus0.data_out !== 8'h3C) begin n_err++; $display("FAIL mid_first_read got=%h exp=3c", bus0.data_out); end
  endtask

  task automatic test_random();
    logic w, r, c;
    for (int i = 0; i < 600; i++) begin
      if ((i / 60) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(w, 8'($urandom), r, c);
      n_vec++; if (st0() !== exp_status()) begin n_err++; $display("FAIL rand_status0 i=%0d got=%h exp=%h", i, st0(), exp_status()); end
      n_vec++; if (st1() !== exp_status()) begin n_err++; $display("FAIL rand_status1 i=%0d got=%h exp=%h", i, st1(), exp_status()); end
      n_vec++; if ({bus0.valid, bus0.data_out} !== {m_valid, m_dout}) begin n_err++; $display("FAIL rand_out0 i=%0d got=%h exp=%h", i, {bus0.valid, bus0.data_out}, {m_valid, m_dout}); end
      n_vec++; if (bus1.valid !== (q.size() > 0)) begin n_err++; $display("FAIL rand_valid1 i=%0d got=%b exp=%b", i, bus1.valid, q.size() > 0); end
      if (q.size() > 0) begin
        n_vec++; if (bus1.data_out !== q[0]) begin n_err++; $display("FAIL rand_head1 i=%0d got=%h exp=%h", i, bus1.data_out, q[0]); end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus0.wr_en = 1'b0; bus0.data_in = '0; bus0.rd_en = 1'b0; bus0.clr_err = 1'b0;
    bus1.wr_en = 1'b0; bus1.data_in = '0; bus1.rd_en = 1'b0; bus1.clr_err = 1'b0;
    q.delete();
    m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_errors();
    test_simultaneous();
    test_fwft();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
